// File: rtl/issue_dispatch_arbiter_pkg.sv
// Shared types and helpers for the issue dispatch arbiter.
//   issue_class_t    : functional-unit class carried with each candidate
//   arb_state_t      : arbiter serialisation state
//   class_budget()   : per-cycle grant budget of a class
package issue_dispatch_arbiter_pkg;

   typedef enum logic [2:0] {
      IC_ALU  = 3'd0,
      IC_MULT = 3'd1,
      IC_CTRL = 3'd2,
      IC_LSU  = 3'd3,
      IC_CSR  = 3'd4,
      IC_FPU  = 3'd5,
      IC_NONE = 3'd7
   } issue_class_t;

   typedef enum logic {
      ST_NORMAL      = 1'b0,
      ST_SERIAL_WAIT = 1'b1
   } arb_state_t;

   localparam int NR_ISSUE_CLASSES = 6;
   localparam int UNLIMITED_BUDGET = 1 << 30;

   // Classes without a functional unit (IC_NONE and the unused encoding 6)
   // are never limited: they only carry exceptions down the pipe.
   function automatic int class_budget(input logic [2:0] cls, input int nr_alu, input int nr_lsu);
      case (cls)
         IC_ALU:                          return nr_alu;
         IC_LSU:                          return nr_lsu;
         IC_MULT, IC_CTRL, IC_CSR, IC_FPU: return 1;
         default:                         return UNLIMITED_BUDGET;
      endcase
   endfunction

endpackage

// File: rtl/issue_dispatch_arbiter_budget.sv
// Per-slot class budget check (purely combinational).
//   i_class : class of every candidate slot
//   o_avail : slot i still fits in its class budget, assuming all lower
//             slots are granted
// Grants form an in-order prefix, so when slot i is considered every lower
// slot is granted; counting same-class lower candidates therefore equals
// counting same-class lower grants, and no dependency on the acks is needed.
module issue_class_budget
   import issue_dispatch_arbiter_pkg::*;
#(
   parameter int NR_ISSUE_PORTS = 2,
   parameter int NR_ALU_SLOTS   = 2,
   parameter int NR_LSU_SLOTS   = 1
) (
   input  logic [NR_ISSUE_PORTS-1:0][2:0] i_class,
   output logic [NR_ISSUE_PORTS-1:0]      o_avail
);

   int w_cnt;

   always_comb begin
      o_avail = '0;
      w_cnt   = 0;
      for (int i = 0; i < NR_ISSUE_PORTS; i++) begin
         w_cnt = 0;
         for (int j = 0; j < i; j++) begin
            if (i_class[j] == i_class[i]) w_cnt = w_cnt + 1;
         end
         o_avail[i] = (w_cnt < class_budget(i_class[i], NR_ALU_SLOTS, NR_LSU_SLOTS));
      end
   end

endmodule

// File: rtl/issue_dispatch_arbiter.sv
// N-wide in-order dispatch arbiter between scoreboard issue ports and FUs.
//   clk_i / rst_i              : clock, synchronous active-high reset
//   flush_i                    : kill this cycle's grants and all state
//   cand_*_i                   : candidate slots, slot 0 oldest
//   cand_ack_o                 : combinational grant (prefix mask)
//   fu_ready_i                 : per-class FU ready
//   resolve_branch_i           : one outstanding branch resolved
//   serial_done_i              : serialising (CSR) instruction committed
//   issue_*_o, class_valid_o   : registered dispatch, one cycle after ack
//   serialising_o              : waiting for a CSR to commit
// MAX_UNRESOLVED_BR must be at least 1.
module issue_dispatch_arbiter
   import issue_dispatch_arbiter_pkg::*;
#(
   parameter int NR_ISSUE_PORTS    = 2,
   parameter int NR_ALU_SLOTS      = 2,
   parameter int NR_LSU_SLOTS      = 1,
   parameter int MAX_UNRESOLVED_BR = 1,
   parameter int TRANS_ID_BITS     = 3
) (
   input  logic                                         clk_i,
   input  logic                                         rst_i,
   input  logic                                         flush_i,
   input  logic [NR_ISSUE_PORTS-1:0]                    cand_valid_i,
   input  logic [NR_ISSUE_PORTS-1:0]                    cand_ops_ready_i,
   input  logic [NR_ISSUE_PORTS-1:0][2:0]               cand_class_i,
   input  logic [NR_ISSUE_PORTS-1:0][TRANS_ID_BITS-1:0] cand_trans_id_i,
   output logic [NR_ISSUE_PORTS-1:0]                    cand_ack_o,
   input  logic [NR_ISSUE_CLASSES-1:0]                  fu_ready_i,
   input  logic                                         resolve_branch_i,
   input  logic                                         serial_done_i,
   output logic [NR_ISSUE_PORTS-1:0]                    issue_valid_o,
   output logic [NR_ISSUE_PORTS-1:0][2:0]               issue_class_o,
   output logic [NR_ISSUE_PORTS-1:0][TRANS_ID_BITS-1:0] issue_trans_id_o,
   output logic [NR_ISSUE_CLASSES-1:0]                  class_valid_o,
   output logic                                         serialising_o
);

   localparam int BR_W = $clog2(MAX_UNRESOLVED_BR + 1);

   arb_state_t                                  r_state;
   logic [BR_W-1:0]                             r_br_cnt;
   logic [NR_ISSUE_PORTS-1:0]                   r_issue_valid;
   logic [NR_ISSUE_PORTS-1:0][2:0]              r_issue_class;
   logic [NR_ISSUE_PORTS-1:0][TRANS_ID_BITS-1:0] r_issue_tid;
   logic [NR_ISSUE_CLASSES-1:0]                 r_class_valid;

   logic [NR_ISSUE_PORTS-1:0]   w_avail;
   logic [NR_ISSUE_PORTS-1:0]   w_ack;
   logic [7:0]                  w_fu_rdy;
   logic                        w_br_full;
   logic                        w_open;
   logic                        w_prefix;
   logic                        w_slot_ok;
   logic                        w_csr_grant;
   logic                        w_ctrl_grant;
   logic [NR_ISSUE_CLASSES-1:0] w_class_grant;

   issue_class_budget #(
      .NR_ISSUE_PORTS (NR_ISSUE_PORTS),
      .NR_ALU_SLOTS   (NR_ALU_SLOTS),
      .NR_LSU_SLOTS   (NR_LSU_SLOTS)
   ) u_budget (
      .i_class (cand_class_i),
      .o_avail (w_avail)
   );

   // Classes with no functional unit always count as ready.
   assign w_fu_rdy  = {2'b11, fu_ready_i};
   assign w_br_full = (r_br_cnt == BR_W'(MAX_UNRESOLVED_BR));
   assign w_open    = (r_state == ST_NORMAL) && !flush_i && !rst_i;

   // A CSR only issues alone from slot 0: any slot above 0 is blocked when
   // it is itself a CSR or when slot 0 is one.
   always_comb begin
      w_ack     = '0;
      w_prefix  = w_open;
      w_slot_ok = 1'b0;
      for (int i = 0; i < NR_ISSUE_PORTS; i++) begin
         w_slot_ok = cand_valid_i[i] && cand_ops_ready_i[i]
                  && w_fu_rdy[cand_class_i[i]] && w_avail[i]
                  && !((cand_class_i[i] == IC_CTRL) && w_br_full)
                  && !((i != 0) && ((cand_class_i[i] == IC_CSR) || (cand_class_i[0] == IC_CSR)));
         w_prefix  = w_prefix && w_slot_ok;
         w_ack[i]  = w_prefix;
      end
   end

   always_comb begin
      w_class_grant = '0;
      w_ctrl_grant  = 1'b0;
      for (int i = 0; i < NR_ISSUE_PORTS; i++) begin
         for (int c = 0; c < NR_ISSUE_CLASSES; c++) begin
            if (w_ack[i] && (cand_class_i[i] == 3'(c))) w_class_grant[c] = 1'b1;
         end
         if (w_ack[i] && (cand_class_i[i] == IC_CTRL)) w_ctrl_grant = 1'b1;
      end
   end

   assign w_csr_grant = w_ack[0] && (cand_class_i[0] == IC_CSR);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state       <= ST_NORMAL;
         r_br_cnt      <= '0;
         r_issue_valid <= '0;
         r_issue_class <= '0;
         r_issue_tid   <= '0;
         r_class_valid <= '0;
      end else begin
         // Acks are already zero under flush, so the valids clear by themselves.
         r_issue_valid <= w_ack;
         r_issue_class <= cand_class_i;
         r_issue_tid   <= cand_trans_id_i;
         r_class_valid <= w_class_grant;
         if (flush_i) begin
            r_state  <= ST_NORMAL;
            r_br_cnt <= '0;
         end else begin
            case (r_state)
               ST_NORMAL:      if (w_csr_grant)   r_state <= ST_SERIAL_WAIT;
               ST_SERIAL_WAIT: if (serial_done_i) r_state <= ST_NORMAL;
               default:                           r_state <= ST_NORMAL;
            endcase
            if (w_ctrl_grant && !resolve_branch_i)
               r_br_cnt <= r_br_cnt + BR_W'(1);
            else if (!w_ctrl_grant && resolve_branch_i && (r_br_cnt != '0))
               r_br_cnt <= r_br_cnt - BR_W'(1);
         end
      end
   end

   // A resolve with nothing outstanding means the branch unit and the
   // arbiter disagree; the counter saturates but this should never happen.
   always_ff @(posedge clk_i) begin
      if (!rst_i && !flush_i && resolve_branch_i && !w_ctrl_grant)
         assert (r_br_cnt != '0);
   end

   assign cand_ack_o       = w_ack;
   assign issue_valid_o    = r_issue_valid;
   assign issue_class_o    = r_issue_class;
   assign issue_trans_id_o = r_issue_tid;
   assign class_valid_o    = r_class_valid;
   assign serialising_o    = (r_state == ST_SERIAL_WAIT);

endmodule

// File: tb/tb_issue_dispatch_arbiter.sv
// Self-checking bench for issue_dispatch_arbiter: directed scenarios plus
// randomized traffic against a slot-walking reference model.
module tb_issue_dispatch_arbiter;
   import issue_dispatch_arbiter_pkg::*;

   localparam int N     = 2;
   localparam int ALU_B = 2;
   localparam int LSU_B = 1;
   localparam int MAXBR = 1;
   localparam int TW    = 3;

   logic                  clk = 1'b0;
   logic                  rst, flush, resolve, sdone;
   logic [N-1:0]          c_valid, c_ops, ack, i_valid;
   logic [N-1:0][2:0]     c_class, i_class;
   logic [N-1:0][TW-1:0]  c_tid, i_tid;
   logic [5:0]            fu_rdy, cls_valid;
   logic                  serialising;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state and expected registered outputs
   bit                   m_serial;
   int                   m_br;
   logic [N-1:0]         e_valid;
   logic [5:0]           e_cv;
   logic [N-1:0][2:0]    e_class;
   logic [N-1:0][TW-1:0] e_tid;

   always #5 clk = ~clk;

   issue_dispatch_arbiter #(
      .NR_ISSUE_PORTS(N), .NR_ALU_SLOTS(ALU_B), .NR_LSU_SLOTS(LSU_B),
      .MAX_UNRESOLVED_BR(MAXBR), .TRANS_ID_BITS(TW)
   ) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .cand_valid_i(c_valid), .cand_ops_ready_i(c_ops),
      .cand_class_i(c_class), .cand_trans_id_i(c_tid),
      .cand_ack_o(ack), .fu_ready_i(fu_rdy),
      .resolve_branch_i(resolve), .serial_done_i(sdone),
      .issue_valid_o(i_valid), .issue_class_o(i_class),
      .issue_trans_id_o(i_tid), .class_valid_o(cls_valid),
      .serialising_o(serialising)
   );

   // Walk the slots oldest first, stop at the first one that cannot go.
   function automatic logic [N-1:0] model_ack();
      logic [N-1:0] a;
      int used[8];
      int cls, lim;
      a = '0;
      for (int k = 0; k < 8; k++) used[k] = 0;
      if (rst || flush || m_serial) return a;
      for (int i = 0; i < N; i++) begin
         cls = int'(c_class[i]);
         lim = (cls == 0) ? ALU_B : (cls == 3) ? LSU_B : (cls >= 6) ? 1000 : 1;
         if (!(c_valid[i] && c_ops[i])) break;
         if (cls < 6 && !fu_rdy[cls]) break;
         if (used[cls] >= lim) break;
         if (cls == 2 && m_br >= MAXBR) break;
         if (cls == 4 && i > 0) break;
         a[i] = 1'b1;
         used[cls]++;
         if (cls == 4) break;
      end
      return a;
   endfunction

   // Advance the model with the current inputs, then clock the DUT.
   task automatic tick();
      logic [N-1:0] a;
      bit ctrl, csr;
      a = model_ack();
      ctrl = 0; csr = 0;
      e_valid = a;
      e_cv = '0;
      for (int i = 0; i < N; i++) begin
         if (a[i] && c_class[i] < 3'd6) e_cv[c_class[i]] = 1'b1;
         if (a[i] && c_class[i] == IC_CTRL) ctrl = 1;
         if (a[i] && c_class[i] == IC_CSR) csr = 1;
      end
      e_class = rst ? '0 : c_class;
      e_tid   = rst ? '0 : c_tid;
      if (rst || flush) begin
         m_serial = 0;
         m_br = 0;
      end else begin
         if (m_serial) begin
            if (sdone) m_serial = 0;
         end else if (csr) m_serial = 1;
         if (ctrl && !resolve) m_br++;
         else if (!ctrl && resolve && m_br > 0) m_br--;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set2(input logic [2:0] c0, input logic [2:0] c1);
      c_valid = 2'b11; c_ops = 2'b11;
      c_class[0] = c0; c_class[1] = c1;
      c_tid[0] = 3'd1; c_tid[1] = 3'd2;
   endtask

   task automatic test_reset();
      rst = 1; flush = 0; resolve = 0; sdone = 0; fu_rdy = '1;
      set2(IC_ALU, IC_ALU);
      #1;
      n_tests++;
      if (ack !== 2'b00) begin n_fail++; $display("FAIL reset_ack got=%b exp=00", ack); end
      tick(); tick();
      n_tests++;
      if (i_valid !== '0 || cls_valid !== '0 || serialising !== 1'b0 || i_class !== '0 || i_tid !== '0) begin
         n_fail++;
         $display("FAIL reset_state valid=%b cv=%b ser=%b cls=%h tid=%h exp all 0", i_valid, cls_valid, serialising, i_class, i_tid);
      end
      rst = 0;
   endtask

   task automatic test_dual_alu();
      set2(IC_ALU, IC_ALU);
      #1;
      n_tests++;
      if (ack !== 2'b11) begin n_fail++; $display("FAIL dual_alu_ack got=%b exp=11", ack); end
      tick();
      n_tests++;
      if (i_valid !== 2'b11 || cls_valid !== 6'b000001) begin
         n_fail++; $display("FAIL dual_alu_issue valid=%b cv=%b exp 11/000001", i_valid, cls_valid);
      end
   endtask

   task automatic test_lsu_budget();
      set2(IC_LSU, IC_LSU);
      #1;
      n_tests++;
      if (ack !== 2'b01) begin n_fail++; $display("FAIL lsu_budget_ack got=%b exp=01", ack); end
      tick();
      c_valid = 2'b01; c_class[0] = IC_LSU; c_tid[0] = 3'd2;
      #1;
      n_tests++;
      if (ack !== 2'b01) begin n_fail++; $display("FAIL lsu_shift_ack got=%b exp=01", ack); end
      tick();
      n_tests++;
      if (i_valid !== 2'b01 || i_tid[0] !== 3'd2 || cls_valid !== 6'b001000) begin
         n_fail++; $display("FAIL lsu_shift_issue valid=%b tid=%0d cv=%b exp 01/2/001000", i_valid, i_tid[0], cls_valid);
      end
   endtask

   task automatic test_inorder();
      set2(IC_ALU, IC_ALU);
      c_ops = 2'b10;
      #1;
      n_tests++;
      if (ack !== 2'b00) begin n_fail++; $display("FAIL inorder_ack got=%b exp=00", ack); end
      tick();
      n_tests++;
      if (i_valid !== 2'b00) begin n_fail++; $display("FAIL inorder_issue got=%b exp=00", i_valid); end
   endtask

   task automatic test_csr_serialise();
      set2(IC_CSR, IC_ALU);
      #1;
      n_tests++;
      if (ack !== 2'b01) begin n_fail++; $display("FAIL csr_ack got=%b exp=01", ack); end
      tick();
      n_tests++;
      if (serialising !== 1'b1 || i_valid !== 2'b01 || cls_valid !== 6'b010000) begin
         n_fail++; $display("FAIL csr_enter ser=%b valid=%b cv=%b exp 1/01/010000", serialising, i_valid, cls_valid);
      end
      set2(IC_ALU, IC_ALU);
      #1;
      n_tests++;
      if (ack !== 2'b00) begin n_fail++; $display("FAIL csr_wait_ack got=%b exp=00", ack); end
      tick();
      sdone = 1;
      #1;
      n_tests++;
      if (ack !== 2'b00 || serialising !== 1'b1) begin
         n_fail++; $display("FAIL csr_done_cycle ack=%b ser=%b exp 00/1", ack, serialising);
      end
      tick();
      sdone = 0;
      #1;
      n_tests++;
      if (serialising !== 1'b0 || ack !== 2'b11) begin
         n_fail++; $display("FAIL csr_exit ser=%b ack=%b exp 0/11", serialising, ack);
      end
      tick();
   endtask

   task automatic test_branch_limit();
      set2(IC_CTRL, IC_ALU);
      #1;
      n_tests++;
      if (ack !== 2'b11) begin n_fail++; $display("FAIL br_first_ack got=%b exp=11", ack); end
      tick();
      n_tests++;
      if (cls_valid !== 6'b000101) begin n_fail++; $display("FAIL br_class_valid got=%b exp=000101", cls_valid); end
      #1;
      n_tests++;
      if (ack !== 2'b00) begin n_fail++; $display("FAIL br_blocked_ack got=%b exp=00", ack); end
      tick();
      set2(IC_ALU, IC_ALU); resolve = 1;
      tick();
      set2(IC_CTRL, IC_ALU);
      #1;
      n_tests++;
      if (ack !== 2'b11) begin n_fail++; $display("FAIL br_after_resolve_ack got=%b exp=11", ack); end
      tick();
      resolve = 0;
      #1;
      n_tests++;
      if (ack !== 2'b11) begin n_fail++; $display("FAIL br_grant_and_resolve_ack got=%b exp=11", ack); end
      tick();
      #1;
      n_tests++;
      if (ack !== 2'b00) begin n_fail++; $display("FAIL br_full_again_ack got=%b exp=00", ack); end
   endtask

   task automatic test_flush();
      set2(IC_CSR, IC_ALU);
      tick();
      set2(IC_CTRL, IC_ALU); flush = 1;
      #1;
      n_tests++;
      if (ack !== 2'b00) begin n_fail++; $display("FAIL flush_ack got=%b exp=00", ack); end
      tick();
      flush = 0;
      #1;
      n_tests++;
      if (i_valid !== 2'b00 || serialising !== 1'b0 || cls_valid !== '0) begin
         n_fail++; $display("FAIL flush_after valid=%b ser=%b cv=%b exp 00/0/0", i_valid, serialising, cls_valid);
      end
      n_tests++;
      if (ack !== 2'b11) begin n_fail++; $display("FAIL flush_br_cleared_ack got=%b exp=11", ack); end
      tick();
   endtask

   task automatic test_random();
      logic [2:0] pick [9] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd5, 3'd7};
      logic [N-1:0] ea;
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int i = 0; i < N; i++) begin
            c_valid[i] = ($urandom % 8) != 0;
            c_ops[i]   = ($urandom % 6) != 0;
            c_class[i] = pick[$urandom % 9];
            c_tid[i]   = TW'($urandom);
         end
         for (int k = 0; k < 6; k++) fu_rdy[k] = ($urandom % 6) != 0;
         flush   = ($urandom % 25) == 0;
         resolve = (m_br > 0) && (($urandom % 3) == 0);
         sdone   = m_serial ? (($urandom % 3) == 0) : (($urandom % 8) == 0);
         #1;
         ea = model_ack();
         n_tests++;
         if (ack !== ea) begin n_fail++; $display("FAIL rand_ack cyc=%0d got=%b exp=%b", cyc, ack, ea); end
         tick();
         n_tests++;
         if (i_valid !== e_valid || cls_valid !== e_cv || serialising !== m_serial) begin
            n_fail++;
            $display("FAIL rand_issue cyc=%0d valid=%b/%b cv=%b/%b ser=%b/%b", cyc, i_valid, e_valid, cls_valid, e_cv, serialising, m_serial);
         end
         for (int i = 0; i < N; i++) begin
            if (e_valid[i]) begin
               n_tests++;
               if (i_class[i] !== e_class[i] || i_tid[i] !== e_tid[i]) begin
                  n_fail++;
                  $display("FAIL rand_payload cyc=%0d slot=%0d cls=%0d/%0d tid=%0d/%0d", cyc, i, i_class[i], e_class[i], i_tid[i], e_tid[i]);
               end
            end
         end
      end
      flush = 0; resolve = 0; sdone = 0; fu_rdy = '1;
   endtask

   task automatic test_reset_mid();
      set2(IC_ALU, IC_ALU);
      tick();
      rst = 1;
      c_tid[0] = 3'd5; c_tid[1] = 3'd6;
      #1;
      n_tests++;
      if (ack !== 2'b00) begin n_fail++; $display("FAIL reset_mid_ack got=%b exp=00", ack); end
      tick();
      rst = 0;
      n_tests++;
      if (i_valid !== '0 || i_tid !== '0 || i_class !== '0 || serialising !== 1'b0) begin
         n_fail++; $display("FAIL reset_mid_state valid=%b tid=%h cls=%h ser=%b exp all 0", i_valid, i_tid, i_class, serialising);
      end
   endtask

   initial begin
      m_serial = 0; m_br = 0;
      test_reset();
      test_dual_alu();
      test_lsu_budget();
      test_inorder();
      test_csr_serialise();
      test_branch_limit();
      test_flush();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
